transpose_buffer: RTL and testbench

TRANSPOSE_BUFFER -- requirements
Module: transpose_buffer

---
 rtl/jpeg_pkg.sv | 10 +
 rtl/transpose_bank.sv | 32 +++
 rtl/transpose_buffer.sv | 91 +++++++++
 tb/tb_transpose_buffer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared sizes and index type for the 8x8 transpose and column DCT stages
package jpeg_pkg;

    localparam int SAMPLE_W = 9;
    localparam int N        = 8;
    localparam int ROW_W    = N * SAMPLE_W;

    typedef logic [2:0] idx_t;

endpackage

// File: rtl/transpose_bank.sv
// rtl/transpose_bank.sv - one 8x8 sample array with a row write port and a combinational column read port
module transpose_bank #(
    parameter int SAMPLE_W = jpeg_pkg::SAMPLE_W,
    parameter int N        = jpeg_pkg::N
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [2:0]            wr_row,
    input  logic [N*SAMPLE_W-1:0] wr_data,
    input  logic [2:0]            rd_col,
    output logic [N*SAMPLE_W-1:0] rd_data
);

    logic [SAMPLE_W-1:0] mem [N][N];

    // Sample j of the incoming row sits at the MSB end for j = 0.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int j = 0; j < N; j++) begin
                mem[wr_row][j] <= wr_data[(N-1-j)*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < N; r++) begin
            rd_data[(N-1-r)*SAMPLE_W +: SAMPLE_W] = mem[r][rd_col];
        end
    end

endmodule

// File: rtl/transpose_buffer.sv
// rtl/transpose_buffer.sv - ping-pong 8x8 transpose buffer between row and column DCT stages
module transpose_buffer #(
    parameter int SAMPLE_W = jpeg_pkg::SAMPLE_W,
    parameter int N        = jpeg_pkg::N
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N*SAMPLE_W-1:0] in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N*SAMPLE_W-1:0] out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            count1,
    output logic                  out_last
);

    localparam int ROW_W = N * SAMPLE_W;

    jpeg_pkg::idx_t   wr_row;
    jpeg_pkg::idx_t   rd_col;
    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       full;
    logic             accept;
    logic             xfer;
    logic [ROW_W-1:0] col0;
    logic [ROW_W-1:0] col1;

    // Gating with reset keeps the handshakes quiet while reset is held.
    assign in_ready  = reset & ~full[wr_bank];
    assign out_valid = reset & full[rd_bank];
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;

    // The set and clear can never hit the same bank in one cycle: the writer
    // only targets an empty bank and the reader only a full one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_col  <= '0;
            full    <= '0;
        end else begin
            if (accept) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (xfer) begin
                rd_col <= rd_col + 3'd1;
                if (rd_col == 3'd7) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end

    transpose_bank #(
        .SAMPLE_W (SAMPLE_W),
        .N        (N)
    ) u_bank0 (
        .clk     (clk),
        .we      (accept & ~wr_bank),
        .wr_row  (wr_row),
        .wr_data (in),
        .rd_col  (rd_col),
        .rd_data (col0)
    );

    transpose_bank #(
        .SAMPLE_W (SAMPLE_W),
        .N        (N)
    ) u_bank1 (
        .clk     (clk),
        .we      (accept & wr_bank),
        .wr_row  (wr_row),
        .wr_data (in),
        .rd_col  (rd_col),
        .rd_data (col1)
    );

    assign out      = out_valid ? (rd_bank ? col1 : col0) : '0;
    assign count1   = rd_col;
    assign out_last = out_valid & (rd_col == 3'd7);

endmodule

// File: tb/tb_transpose_buffer.sv
// tb/tb_transpose_buffer.sv - directed self-checking bench for transpose_buffer
module tb_transpose_buffer;

    localparam int RW = jpeg_pkg::ROW_W;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] in;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] out;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    count1;
    logic          out_last;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    transpose_buffer #(
        .SAMPLE_W (9),
        .N        (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count1    (count1),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: counting pattern offset per block; mode 1: rows alternate -256 / +255
    function automatic logic [8:0] smp(input int mode, input int blk, input int r, input int j);
        if (mode == 1) return (r % 2 == 0) ? 9'h100 : 9'h0FF;
        return 9'((blk * 37 + 8 * r + j) % 512);
    endfunction

    function automatic logic [RW-1:0] row_of(input int mode, input int blk, input int r);
        logic [RW-1:0] v;
        for (int j = 0; j < 8; j++) v[(7-j)*9 +: 9] = smp(mode, blk, r, j);
        return v;
    endfunction

    function automatic logic [RW-1:0] col_of(input int mode, input int blk, input int c);
        logic [RW-1:0] v;
        for (int r = 0; r < 8; r++) v[(7-r)*9 +: 9] = smp(mode, blk, r, c);
        return v;
    endfunction

    // Streams nblk blocks with out_ready held high; column k is due in cycle k+8.
    task automatic stream(input int mode, input int nblk, input int base, input string tag);
        int nrows;
        nrows = nblk * 8;
        out_ready = 1'b1;
        for (int t = 0; t < nrows + 8; t++) begin
            in_valid = (t < nrows);
            in       = (t < nrows) ? row_of(mode, base + t / 8, t % 8) : '0;
            if (t <= nrows)
                check($sformatf("%s_rdy_t%0d", tag, t), RW'(in_ready), RW'(1'b1));
            if (t < 8) begin
                check($sformatf("%s_vld_t%0d", tag, t), RW'(out_valid), RW'(1'b0));
            end else begin
                check($sformatf("%s_vld_t%0d", tag, t), RW'(out_valid), RW'(1'b1));
                check($sformatf("%s_cnt_t%0d", tag, t), RW'(count1), RW'((t - 8) % 8));
                check($sformatf("%s_last_t%0d", tag, t), RW'(out_last), RW'((t - 8) % 8 == 7));
                check($sformatf("%s_col_t%0d", tag, t), out, col_of(mode, base + (t - 8) / 8, (t - 8) % 8));
            end
            tick();
        end
        in_valid = 1'b0;
        check($sformatf("%s_idle_vld", tag), RW'(out_valid), RW'(1'b0));
        check($sformatf("%s_idle_out", tag), out, '0);
    endtask

    initial begin
        reset     = 1'b0;
        in        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", RW'(in_ready), RW'(1'b0));
        check("rst_out_valid", RW'(out_valid), RW'(1'b0));
        check("rst_out", out, '0);
        check("rst_count1", RW'(count1), '0);
        check("rst_out_last", RW'(out_last), RW'(1'b0));
        reset = 1'b1;
        #1;
        check("rel_in_ready", RW'(in_ready), RW'(1'b1));
        tick();

        stream(0, 1, 0, "single");
        stream(0, 4, 0, "stream");

        // Consumer stall: 16 rows fill both banks, the 17th must bounce.
        out_ready = 1'b0;
        for (int t = 0; t < 20; t++) begin
            in_valid = 1'b1;
            if (t < 16) begin
                in = row_of(0, 4 + t / 8, t % 8);
                check($sformatf("stall_rdy_t%0d", t), RW'(in_ready), RW'(1'b1));
            end else begin
                in = {8{9'h155}};
                check($sformatf("stall_blk_t%0d", t), RW'(in_ready), RW'(1'b0));
            end
            if (t >= 8) begin
                check($sformatf("stall_vld_t%0d", t), RW'(out_valid), RW'(1'b1));
                check($sformatf("stall_cnt_t%0d", t), RW'(count1), '0);
                check($sformatf("stall_col_t%0d", t), out, col_of(0, 4, 0));
                check($sformatf("stall_last_t%0d", t), RW'(out_last), RW'(1'b0));
            end else begin
                check($sformatf("stall_vld_t%0d", t), RW'(out_valid), RW'(1'b0));
            end
            tick();
        end
        in_valid  = 1'b0;
        in        = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("drain_vld_k%0d", k), RW'(out_valid), RW'(1'b1));
            check($sformatf("drain_cnt_k%0d", k), RW'(count1), RW'(k % 8));
            check($sformatf("drain_col_k%0d", k), out, col_of(0, 4 + k / 8, k % 8));
            check($sformatf("drain_last_k%0d", k), RW'(out_last), RW'(k % 8 == 7));
            tick();
        end
        check("drain_idle_vld", RW'(out_valid), RW'(1'b0));

        stream(1, 1, 0, "signed");

        // Reset after 5 rows of a block: the partial block must vanish.
        out_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            in       = row_of(0, 6, r);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("mid_rst_in_ready", RW'(in_ready), RW'(1'b0));
        tick();
        reset = 1'b1;
        #1;
        check("mid_rel_vld", RW'(out_valid), RW'(1'b0));
        check("mid_rel_cnt", RW'(count1), '0);
        check("mid_rel_rdy", RW'(in_ready), RW'(1'b1));
        tick();
        stream(0, 1, 7, "newblk");

        // From a clean reset, bank 0's last column and bank 1's last row share cycle 15.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        stream(0, 2, 8, "simul");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
